icache_req_arbiter: RTL and testbench



---
 rtl/icache_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_icache_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_req_arbiter.sv
// icache_req_arbiter
// Shares the single ICache request port between the fetch-stage demand
// requester and a next-line prefetcher. Tracks the one outstanding request,
// steers its response to the owner, sequences kill/drain on flush or on a
// demand that conflicts with an in-flight prefetch, and promotes an in-flight
// prefetch to the demand when both target the same 16-byte line.
// Build option: define ICACHE_ARB_PREFETCH_EN to enable the prefetch path.
// Without it pf_valid_i is ignored, pf_ready_o / pf_resp_valid_o and both
// statistics counters stay 0, and WAIT_PF is never entered.
module icache_req_arbiter #(
    parameter int VADDR_W = 40,
    parameter int LINE_W  = 128,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               dem_valid_i,
    input  logic [VADDR_W-1:0] dem_vaddr_i,
    output logic               dem_ready_o,
    output logic               dem_resp_valid_o,
    output logic [LINE_W-1:0]  dem_resp_data_o,
    output logic               dem_resp_xcpt_o,
    input  logic               pf_valid_i,
    input  logic [VADDR_W-1:0] pf_vaddr_i,
    output logic               pf_ready_o,
    output logic               pf_resp_valid_o,
    input  logic               flush_i,
    output logic               icache_req_valid_o,
    input  logic               icache_req_ready_i,
    output logic [VADDR_W-1:0] icache_req_vaddr_o,
    output logic               icache_req_kill_o,
    input  logic               icache_resp_valid_i,
    input  logic [LINE_W-1:0]  icache_resp_data_i,
    input  logic               icache_resp_xcpt_i,
    output logic [CNT_W-1:0]   pf_hit_cnt_o,
    output logic [CNT_W-1:0]   pf_drop_cnt_o
);

`ifdef ICACHE_ARB_PREFETCH_EN
    localparam logic PF_EN = 1'b1;
`else
    localparam logic PF_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_DEM = 2'd1;
    localparam logic [1:0] S_WAIT_PF  = 2'd2;
    localparam logic [1:0] S_DRAIN    = 2'd3;
    localparam int         LINE_AW    = VADDR_W - 4;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [LINE_AW-1:0] r_line;
    logic [CNT_W-1:0]   r_pf_hit_cnt;
    logic [CNT_W-1:0]   r_pf_drop_cnt;

    logic w_in_wait;
    logic w_in_wait_pf;
    logic w_dem_line_match;
    logic w_promote;
    logic w_pf_mismatch_kill;
    logic w_flush_kill;
    logic w_resp_live;
    logic w_issue_window;
    logic w_issue_dem;
    logic w_issue_pf;
    logic w_accept;
    logic w_dem_resp;
    logic w_drop_inc;

    assign w_in_wait        = (r_state == S_WAIT_DEM) | (r_state == S_WAIT_PF);
    assign w_in_wait_pf     = PF_EN & (r_state == S_WAIT_PF);
    assign w_dem_line_match = (dem_vaddr_i[VADDR_W-1:4] == r_line);

    // Flush outranks both promotion and response delivery.
    assign w_promote          = w_in_wait_pf & ~flush_i & dem_valid_i & w_dem_line_match;
    assign w_pf_mismatch_kill = w_in_wait_pf & ~flush_i & dem_valid_i & ~w_dem_line_match
                                & ~icache_resp_valid_i;
    assign w_flush_kill       = w_in_wait & flush_i;
    assign w_resp_live        = w_in_wait & icache_resp_valid_i & ~flush_i;

    // A new request may go out when idle or when the outstanding one completes
    // this cycle. A promoted demand is already served, so only a prefetch may
    // follow it in that cycle.
    assign w_issue_window = ((r_state == S_IDLE) & ~flush_i) | w_resp_live;
    assign w_issue_dem    = w_issue_window & dem_valid_i & ~w_promote;
    assign w_issue_pf     = w_issue_window & PF_EN & pf_valid_i & ~w_issue_dem;
    assign w_accept       = (w_issue_dem | w_issue_pf) & icache_req_ready_i;

    assign icache_req_valid_o = w_issue_dem | w_issue_pf;
    assign icache_req_vaddr_o = w_issue_dem ? dem_vaddr_i :
                                (w_issue_pf ? pf_vaddr_i : '0);
    assign icache_req_kill_o  = w_flush_kill | w_pf_mismatch_kill;

    assign dem_ready_o = (w_issue_dem & icache_req_ready_i) | w_promote;
    assign pf_ready_o  = w_issue_pf & icache_req_ready_i;

    assign w_dem_resp       = w_resp_live & ((r_state == S_WAIT_DEM) | w_promote);
    assign dem_resp_valid_o = w_dem_resp;
    assign dem_resp_data_o  = w_dem_resp ? icache_resp_data_i : '0;
    assign dem_resp_xcpt_o  = w_dem_resp & icache_resp_xcpt_i;
    assign pf_resp_valid_o  = w_resp_live & w_in_wait_pf & ~w_promote;

    assign w_drop_inc    = w_pf_mismatch_kill | (w_in_wait_pf & flush_i);
    assign pf_hit_cnt_o  = r_pf_hit_cnt;
    assign pf_drop_cnt_o = r_pf_drop_cnt;

    // Next-state selection; an accepted issue overrides the completion path.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT_DEM, S_WAIT_PF: begin
                if (flush_i) begin
                    w_state_next = icache_resp_valid_i ? S_IDLE : S_DRAIN;
                end else if (icache_resp_valid_i) begin
                    w_state_next = S_IDLE;
                end else if (w_promote) begin
                    w_state_next = S_WAIT_DEM;
                end else if (w_pf_mismatch_kill) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (icache_resp_valid_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_accept) begin
            w_state_next = w_issue_dem ? S_WAIT_DEM : S_WAIT_PF;
        end
    end

    // State and outstanding line address.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_line  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_line <= icache_req_vaddr_o[VADDR_W-1:4];
            end
        end
    end

    // Saturating prefetch statistics.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pf_hit_cnt  <= '0;
            r_pf_drop_cnt <= '0;
        end else begin
            if (w_promote && (r_pf_hit_cnt != {CNT_W{1'b1}})) begin
                r_pf_hit_cnt <= r_pf_hit_cnt + 1'b1;
            end
            if (w_drop_inc && (r_pf_drop_cnt != {CNT_W{1'b1}})) begin
                r_pf_drop_cnt <= r_pf_drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_req_arbiter.sv
// Testbench for icache_req_arbiter: directed scenarios with literal
// expectations followed by randomized traffic, all checked each cycle against
// a transaction-level model of the arbiter plus a simple ICache responder.
// Honors ICACHE_ARB_PREFETCH_EN the same way the design does.
module tb_icache_req_arbiter;
    localparam int VADDR_W = 40;
    localparam int LINE_W  = 128;
    localparam int CNT_W   = 16;
`ifdef ICACHE_ARB_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif
    localparam logic [127:0] D_LIT = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    logic               clk_i = 1'b0;
    logic               rstn_i = 1'b1;
    logic               dem_valid_i = 1'b0;
    logic [VADDR_W-1:0] dem_vaddr_i = '0;
    logic               dem_ready_o;
    logic               dem_resp_valid_o;
    logic [LINE_W-1:0]  dem_resp_data_o;
    logic               dem_resp_xcpt_o;
    logic               pf_valid_i = 1'b0;
    logic [VADDR_W-1:0] pf_vaddr_i = '0;
    logic               pf_ready_o;
    logic               pf_resp_valid_o;
    logic               flush_i = 1'b0;
    logic               icache_req_valid_o;
    logic               icache_req_ready_i = 1'b0;
    logic [VADDR_W-1:0] icache_req_vaddr_o;
    logic               icache_req_kill_o;
    logic               icache_resp_valid_i = 1'b0;
    logic [LINE_W-1:0]  icache_resp_data_i = '0;
    logic               icache_resp_xcpt_i = 1'b0;
    logic [CNT_W-1:0]   pf_hit_cnt_o;
    logic [CNT_W-1:0]   pf_drop_cnt_o;

    always #5 clk_i = ~clk_i;

    icache_req_arbiter #(.VADDR_W(VADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .dem_valid_i(dem_valid_i), .dem_vaddr_i(dem_vaddr_i), .dem_ready_o(dem_ready_o),
        .dem_resp_valid_o(dem_resp_valid_o), .dem_resp_data_o(dem_resp_data_o),
        .dem_resp_xcpt_o(dem_resp_xcpt_o),
        .pf_valid_i(pf_valid_i), .pf_vaddr_i(pf_vaddr_i), .pf_ready_o(pf_ready_o),
        .pf_resp_valid_o(pf_resp_valid_o), .flush_i(flush_i),
        .icache_req_valid_o(icache_req_valid_o), .icache_req_ready_i(icache_req_ready_i),
        .icache_req_vaddr_o(icache_req_vaddr_o), .icache_req_kill_o(icache_req_kill_o),
        .icache_resp_valid_i(icache_resp_valid_i), .icache_resp_data_i(icache_resp_data_i),
        .icache_resp_xcpt_i(icache_resp_xcpt_i),
        .pf_hit_cnt_o(pf_hit_cnt_o), .pf_drop_cnt_o(pf_drop_cnt_o)
    );

    int checks = 0;
    int failures = 0;

    // Arbiter model: is a request outstanding, who owns it, was it killed.
    bit          m_busy;
    bit          m_owner_pf;
    bit          m_dead;
    logic [35:0] m_line;
    int          m_hit;
    int          m_drop;
    // ICache model: one request in flight, answered after a set latency.
    bit          ic_busy;
    int          ic_cnt;
    int          lat_next = 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner_pf = 0; m_dead = 0; m_line = '0;
        m_hit = 0; m_drop = 0; ic_busy = 0; ic_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        dem_valid_i = 0; dem_vaddr_i = '0; pf_valid_i = 0; pf_vaddr_i = '0;
        flush_i = 0; icache_req_ready_i = 0; icache_resp_valid_i = 0;
        icache_resp_data_i = '0; icache_resp_xcpt_i = 0;
        rstn_i = 0;
        #1;
        chk("rst_dem_ready", dem_ready_o, 0);
        chk("rst_dem_resp_valid", dem_resp_valid_o, 0);
        chk("rst_dem_resp_data", dem_resp_data_o, 0);
        chk("rst_pf_ready", pf_ready_o, 0);
        chk("rst_pf_resp_valid", pf_resp_valid_o, 0);
        chk("rst_req_valid", icache_req_valid_o, 0);
        chk("rst_req_vaddr", icache_req_vaddr_o, 0);
        chk("rst_kill", icache_req_kill_o, 0);
        chk("rst_hit_cnt", pf_hit_cnt_o, 0);
        chk("rst_drop_cnt", pf_drop_cnt_o, 0);
        model_reset();
        repeat (2) @(negedge clk_i);
        rstn_i = 1;
    endtask

    // One clock of stimulus; compare all outputs against the model, then advance it.
    task automatic step(input bit dv, input logic [39:0] da, input bit pv, input logic [39:0] pa,
                        input bit fl, input bit rdy, input logic [127:0] rd, input bit rx);
        bit rv, promo, can_issue, req_pf, hit_inc, drop_inc;
        bit e_dready, e_pready, e_dresp, e_presp, e_req, e_kill, e_xcpt;
        logic [127:0] e_data;
        logic [39:0]  e_addr;
        bit n_busy, n_owner_pf, n_dead;
        logic [35:0] n_line;
        @(negedge clk_i);
        rv = ic_busy && (ic_cnt == 0);
        dem_valid_i = dv; dem_vaddr_i = da; pf_valid_i = pv; pf_vaddr_i = pa;
        flush_i = fl; icache_req_ready_i = rdy; icache_resp_valid_i = rv;
        icache_resp_data_i = rd; icache_resp_xcpt_i = rx;
        #1;
        promo = 0; can_issue = 0; req_pf = 0; hit_inc = 0; drop_inc = 0;
        e_dready = 0; e_pready = 0; e_dresp = 0; e_presp = 0; e_req = 0; e_kill = 0;
        e_xcpt = 0; e_data = '0; e_addr = '0;
        n_busy = m_busy; n_owner_pf = m_owner_pf; n_dead = m_dead; n_line = m_line;
        if (!m_busy) begin
            can_issue = !fl;
        end else if (m_dead) begin
            if (rv) n_busy = 0;
        end else if (fl) begin
            e_kill = 1;
            if (m_owner_pf) drop_inc = 1;
            if (rv) n_busy = 0; else n_dead = 1;
        end else begin
            promo = m_owner_pf && dv && (da[39:4] == m_line);
            if (promo) begin e_dready = 1; hit_inc = 1; n_owner_pf = 0; end
            if (rv) begin
                if (m_owner_pf && !promo) e_presp = 1;
                else begin e_dresp = 1; e_data = rd; e_xcpt = rx; end
                n_busy = 0;
                can_issue = 1;
            end else if (m_owner_pf && dv && !promo) begin
                e_kill = 1; drop_inc = 1; n_dead = 1;
            end
        end
        if (can_issue) begin
            if (dv && !promo) begin e_req = 1; e_addr = da; req_pf = 0; end
            else if (pv && PF_EN) begin e_req = 1; e_addr = pa; req_pf = 1; end
        end
        if (e_req && rdy) begin
            if (req_pf) e_pready = 1; else e_dready = 1;
            n_busy = 1; n_dead = 0; n_owner_pf = req_pf; n_line = e_addr[39:4];
        end
        chk("dem_ready", dem_ready_o, e_dready);
        chk("pf_ready", pf_ready_o, e_pready);
        chk("dem_resp_valid", dem_resp_valid_o, e_dresp);
        chk("pf_resp_valid", pf_resp_valid_o, e_presp);
        chk("req_valid", icache_req_valid_o, e_req);
        chk("req_kill", icache_req_kill_o, e_kill);
        chk("hit_cnt", pf_hit_cnt_o, m_hit);
        chk("drop_cnt", pf_drop_cnt_o, m_drop);
        if (e_req) chk("req_vaddr", icache_req_vaddr_o, e_addr);
        if (e_dresp) begin
            chk("dem_resp_data", dem_resp_data_o, e_data);
            chk("dem_resp_xcpt", dem_resp_xcpt_o, e_xcpt);
        end
        m_busy = n_busy; m_owner_pf = n_owner_pf; m_dead = n_dead; m_line = n_line;
        if (hit_inc && m_hit != 65535) m_hit++;
        if (drop_inc && m_drop != 65535) m_drop++;
        if (rv) ic_busy = 0;
        else if (ic_busy) ic_cnt--;
        if (e_req && rdy) begin ic_busy = 1; ic_cnt = lat_next - 1; end
    endtask

    task automatic idle_step();
        step(0, '0, 0, '0, 0, 1, D_LIT, 0);
    endtask

    task automatic drain_all();
        int n = 0;
        while (ic_busy && n < 12) begin idle_step(); n++; end
        if (ic_busy) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=busy required=idle");
        end
    endtask

    initial begin
        do_reset();

        // Plain demand, 3-cycle ICache latency.
        lat_next = 3;
        step(1, 40'h80000010, 0, '0, 0, 1, D_LIT, 0);
        chk("t1_dem_ready", dem_ready_o, 1);
        chk("t1_req_vaddr", icache_req_vaddr_o, 40'h80000010);
        idle_step(); idle_step();
        chk("t1_no_resp_yet", dem_resp_valid_o, 0);
        idle_step();
        chk("t1_resp_valid", dem_resp_valid_o, 1);
        chk("t1_resp_data", dem_resp_data_o, D_LIT);
        chk("t1_no_pf_resp", pf_resp_valid_o, 0);
        drain_all();

        // Prefetch then same-line demand: promotion.
        lat_next = 2;
        step(0, '0, 1, 40'h80000020, 0, 1, D_LIT, 0);
        chk("t2_pf_ready", pf_ready_o, PF_EN);
        step(1, 40'h80000024, 0, '0, 0, 1, D_LIT, 0);
        chk("t2_dem_ready", dem_ready_o, 1);
`ifdef ICACHE_ARB_PREFETCH_EN
        chk("t2_no_req", icache_req_valid_o, 0);
        idle_step();
        chk("t2_resp_to_dem", dem_resp_valid_o, 1);
        chk("t2_no_pf_resp", pf_resp_valid_o, 0);
        chk("t2_hit_cnt", pf_hit_cnt_o, 1);
`endif
        drain_all();

        // Prefetch then different-line demand: kill and drain.
        lat_next = 3;
        step(0, '0, 1, 40'h80000020, 0, 1, D_LIT, 0);
        step(1, 40'h80000100, 0, '0, 0, 1, D_LIT, 0);
`ifdef ICACHE_ARB_PREFETCH_EN
        chk("t3_kill", icache_req_kill_o, 1);
        chk("t3_dem_not_ready", dem_ready_o, 0);
        step(1, 40'h80000100, 0, '0, 0, 1, D_LIT, 0);
        chk("t3_kill_one_cycle", icache_req_kill_o, 0);
        chk("t3_drop_cnt", pf_drop_cnt_o, 1);
        step(1, 40'h80000100, 0, '0, 0, 1, D_LIT, 0);
        chk("t3_resp_discarded", dem_resp_valid_o, 0);
        chk("t3_no_pf_resp", pf_resp_valid_o, 0);
        step(1, 40'h80000100, 0, '0, 0, 1, D_LIT, 0);
        chk("t3_reissue", icache_req_valid_o, 1);
        chk("t3_reissue_addr", icache_req_vaddr_o, 40'h80000100);
`endif
        drain_all();

        // Flush while waiting on a demand.
        lat_next = 3;
        step(1, 40'h80000040, 0, '0, 0, 1, D_LIT, 0);
        step(0, '0, 0, '0, 1, 1, D_LIT, 0);
        chk("t4_kill", icache_req_kill_o, 1);
        idle_step();
        chk("t4_kill_one_cycle", icache_req_kill_o, 0);
        idle_step();
        chk("t4_resp_discarded", dem_resp_valid_o, 0);
        step(1, 40'h80000050, 0, '0, 0, 1, D_LIT, 0);
        chk("t4_idle_issue", icache_req_valid_o, 1);
        drain_all();

        // Response and new demand in the same cycle.
        lat_next = 2;
        step(1, 40'h80000060, 0, '0, 0, 1, D_LIT, 0);
        idle_step();
        step(1, 40'h80000070, 0, '0, 0, 1, D_LIT, 0);
        chk("t5_resp", dem_resp_valid_o, 1);
        chk("t5_b2b_req", icache_req_valid_o, 1);
        chk("t5_b2b_ready", dem_ready_o, 1);
        drain_all();
        step(0, '0, 1, 40'h80000080, 0, 1, D_LIT, 0);
        chk("t5_pf_ready_cfg", pf_ready_o, PF_EN);
        drain_all();

        // Randomized traffic with a reset in the middle.
        for (int c = 0; c < 4000; c++) begin
            logic [39:0] da, pa;
            logic [127:0] rd;
            if (c == 2000) do_reset();
            lat_next = $urandom_range(1, 4);
            da = 40'h80000000 + 40'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
            pa = 40'h80000000 + 40'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
            rd = {$urandom, $urandom, $urandom, $urandom};
            step(1'($urandom_range(0, 1)), da, 1'($urandom_range(0, 1)), pa,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, rd,
                 $urandom_range(0, 7) == 0);
        end
        drain_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
